// File: rtl/meta_data_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : meta_data_arb_pkg
// Description : Shared types, limits and round-robin helper for the metadata
//               stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package meta_data_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int MAX_IW  = $clog2(MAX_REQ);

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    // First set bit of req scanning ptr, ptr+1, ... mod n; returns ptr when none set.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
        int idx;
        int res;
        res = ptr;
        idx = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[MAX_IW-1:0]]) begin
                    res = idx;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/meta_data_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : meta_data_out_reg
// Description : Single-entry valid/ready pipeline register for data/keep/last.
// Revision    : 1.0 - initial release
// ============================================================================
module meta_data_out_reg #(
    parameter int DW = 512,
    localparam int KW = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic [KW-1:0] i_keep,
    input  logic          i_last,
    output logic          o_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [KW-1:0] o_keep,
    output logic          o_last,
    input  logic          i_ready
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [KW-1:0] r_keep;
    logic          r_last;
    logic          w_ready;

    // Accepting while draining keeps one beat per cycle through the stage.
    assign w_ready = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (i_valid && w_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/meta_data_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : meta_data_rr_arbiter
// Description : Packet-granular round-robin merge of N metadata AXI-Stream
//               sources onto one registered output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module meta_data_rr_arbiter
    import meta_data_arb_pkg::*;
#(
    parameter int DW = 512,
    parameter int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N*DW-1:0]   S_AXIS_MD_TDATA,
    input  logic [N*DW/8-1:0] S_AXIS_MD_TKEEP,
    input  logic [N-1:0]      S_AXIS_MD_TLAST,
    input  logic [N-1:0]      S_AXIS_MD_TVALID,
    output logic [N-1:0]      S_AXIS_MD_TREADY,
    output logic [DW-1:0]     M_AXIS_MD_TDATA,
    output logic [DW/8-1:0]   M_AXIS_MD_TKEEP,
    output logic              M_AXIS_MD_TLAST,
    output logic              M_AXIS_MD_TVALID,
    input  logic              M_AXIS_MD_TREADY,
    output logic [IW-1:0]     GRANT_ID,
    output logic              BUSY
);

    localparam int KW = DW / 8;

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] w_grant_nxt;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] w_rr_ptr_nxt;

    logic          w_out_ready;
    logic          w_sel_valid;
    logic [DW-1:0] w_sel_data;
    logic [KW-1:0] w_sel_keep;
    logic          w_sel_last;
    logic          w_load_valid;
    logic          w_accept;

    assign w_sel_valid  = S_AXIS_MD_TVALID[r_grant];
    assign w_sel_data   = S_AXIS_MD_TDATA[r_grant*DW +: DW];
    assign w_sel_keep   = S_AXIS_MD_TKEEP[r_grant*KW +: KW];
    assign w_sel_last   = S_AXIS_MD_TLAST[r_grant];
    assign w_load_valid = (r_state == ARB_LOCK) && w_sel_valid;
    assign w_accept     = w_load_valid && w_out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (|S_AXIS_MD_TVALID) begin
                    w_grant_nxt = IW'(rr_pick(MAX_REQ'(S_AXIS_MD_TVALID), int'(r_rr_ptr), N));
                    w_state_nxt = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                // The grant is released only by an accepted TLAST beat.
                if (w_accept && w_sel_last) begin
                    w_state_nxt  = ARB_IDLE;
                    w_rr_ptr_nxt = (r_grant == IW'(N - 1)) ? '0 : r_grant + IW'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        S_AXIS_MD_TREADY = '0;
        if (r_state == ARB_LOCK) begin
            S_AXIS_MD_TREADY[r_grant] = w_out_ready;
        end
    end

    meta_data_out_reg #(
        .DW (DW)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (resetn),
        .i_valid (w_load_valid),
        .i_data  (w_sel_data),
        .i_keep  (w_sel_keep),
        .i_last  (w_sel_last),
        .o_ready (w_out_ready),
        .o_valid (M_AXIS_MD_TVALID),
        .o_data  (M_AXIS_MD_TDATA),
        .o_keep  (M_AXIS_MD_TKEEP),
        .o_last  (M_AXIS_MD_TLAST),
        .i_ready (M_AXIS_MD_TREADY)
    );

    assign GRANT_ID = r_grant;
    assign BUSY     = (r_state == ARB_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_meta_data_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_meta_data_rr_arbiter
// Description : Self-checking bench against a queue-based arbiter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_meta_data_rr_arbiter;

    localparam int DW = 512;
    localparam int N  = 4;
    localparam int KW = DW / 8;
    localparam int IW = $clog2(N);

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N*DW-1:0]   s_data;
    logic [N*KW-1:0]   s_keep;
    logic [N-1:0]      s_last;
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    logic [DW-1:0]     m_data;
    logic [KW-1:0]     m_keep;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic [IW-1:0]     grant_id;
    logic              busy;

    meta_data_rr_arbiter #(.DW(DW), .N(N)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .S_AXIS_MD_TDATA  (s_data),
        .S_AXIS_MD_TKEEP  (s_keep),
        .S_AXIS_MD_TLAST  (s_last),
        .S_AXIS_MD_TVALID (s_valid),
        .S_AXIS_MD_TREADY (s_ready),
        .M_AXIS_MD_TDATA  (m_data),
        .M_AXIS_MD_TKEEP  (m_keep),
        .M_AXIS_MD_TLAST  (m_last),
        .M_AXIS_MD_TVALID (m_valid),
        .M_AXIS_MD_TREADY (m_ready),
        .GRANT_ID         (grant_id),
        .BUSY             (busy)
    );

    always #5 clk = ~clk;

    beat_t src_q[N][$];
    beat_t exp_q[$];
    bit    m_lock;
    int    m_gnt;
    int    m_ptr;
    bit    vmask[N];
    bit    rnd_valid;
    bit    rnd_ready;
    bit    rdy_force;
    int    n_cmp;
    int    n_err;
    int    grant_log[$];
    bit    prev_busy;
    int    out_beats;
    int    out_bytes;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_lock    = 1'b0;
        m_gnt     = 0;
        m_ptr     = 0;
        prev_busy = 1'b0;
    endtask

    task automatic push_pkt(input int src, input int len, input bit rnd);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            for (int w = 0; w < DW / 32; w++) begin
                b.d[w*32 +: 32] = rnd ? $urandom() : 32'(src * 256 + j + 1);
            end
            b.k = rnd ? {$urandom(), $urandom()} : '1;
            b.l = (j == len - 1);
            src_q[src].push_back(b);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_valid[i] = (src_q[i].size() > 0) && vmask[i] && (!rnd_valid || $urandom_range(3) != 0);
            s_data[i*DW +: DW] = (src_q[i].size() > 0) ? src_q[i][0].d : '0;
            s_keep[i*KW +: KW] = (src_q[i].size() > 0) ? src_q[i][0].k : '0;
            s_last[i]          = (src_q[i].size() > 0) ? src_q[i][0].l : 1'b0;
        end
        m_ready = rnd_ready ? ($urandom_range(3) != 0) : rdy_force;
    endtask

    task automatic check();
        logic [N-1:0] er;
        er = '0;
        if (m_lock && (exp_q.size() == 0 || m_ready)) er[m_gnt] = 1'b1;
        chk("m_tvalid", m_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("m_tdata", m_data, exp_q[0].d);
            chk("m_tkeep", m_keep, exp_q[0].k);
            chk("m_tlast", m_last, exp_q[0].l);
        end
        chk("s_tready", s_ready, er);
        chk("grant_id", grant_id, m_gnt);
        chk("busy", busy, m_lock);
        if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
        if (m_valid && m_ready) begin
            out_beats++;
            out_bytes += $countones(m_keep);
        end
    endtask

    // Reference behaviour: one transfer per side per edge, grant chosen by rotation scan.
    task automatic update();
        bit    pop;
        bit    acc;
        beat_t b;
        pop = (exp_q.size() > 0) && m_ready;
        acc = m_lock && s_valid[m_gnt] && (exp_q.size() == 0 || m_ready);
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            b = src_q[m_gnt].pop_front();
            exp_q.push_back(b);
            if (b.l) begin
                m_lock = 1'b0;
                m_ptr  = (m_gnt + 1) % N;
            end
        end else if (!m_lock && (|s_valid)) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (s_valid[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
            end
            m_lock = 1'b1;
        end
    endtask

    task automatic cycle(input int n);
        for (int c = 0; c < n; c++) begin
            drive();
            @(negedge clk);
            check();
            @(posedge clk);
            update();
            #1;
        end
    endtask

    task automatic check_reset();
        chk("rst_m_tvalid", m_valid, 0);
        chk("rst_m_tdata", m_data, 0);
        chk("rst_m_tkeep", m_keep, 0);
        chk("rst_m_tlast", m_last, 0);
        chk("rst_s_tready", s_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        model_reset();
        s_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        s_data = '0; s_keep = '0; s_last = '0; s_valid = '0; m_ready = 1'b0;
        rnd_valid = 1'b0; rnd_ready = 1'b0; rdy_force = 1'b1;
        for (int i = 0; i < N; i++) vmask[i] = 1'b1;
        apply_reset();

        // Single requester, 3-beat packet.
        begin
            beat_t b;
            for (int j = 0; j < 3; j++) begin
                b.d = DW'(8'hA1 + j); b.k = '1; b.l = (j == 2);
                src_q[2].push_back(b);
            end
        end
        grant_log.delete(); out_beats = 0;
        cycle(8);
        chk("s1_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
        chk("s1_beats", out_beats, 3);

        // Round-robin fairness with single-beat packets.
        apply_reset();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_pkt(i, 1, 1'b0);
        grant_log.delete(); out_beats = 0;
        cycle(20);
        begin
            int exp_order[6] = '{0, 1, 2, 3, 0, 1};
            for (int j = 0; j < 6; j++)
                chk("rr_order", (grant_log.size() > j) ? grant_log[j] : -1, exp_order[j]);
        end
        chk("rr_beats", out_beats, 8);

        // Downstream backpressure mid-packet.
        apply_reset();
        push_pkt(0, 6, 1'b0);
        src_q[0][5].k = 64'h00FF;
        out_beats = 0; out_bytes = 0;
        rdy_force = 1'b1; cycle(4);
        rdy_force = 1'b0; cycle(5);
        rdy_force = 1'b1; cycle(10);
        chk("bp_beats", out_beats, 6);
        chk("bp_bytes", out_bytes, 5 * 64 + 8);

        // Granted source stalls while others request.
        for (int i = 0; i < N; i++) vmask[i] = (i == 1);
        push_pkt(1, 4, 1'b0);
        push_pkt(0, 1, 1'b0);
        push_pkt(3, 1, 1'b0);
        out_beats = 0;
        cycle(3);
        vmask[1] = 1'b0; vmask[0] = 1'b1; vmask[3] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle(1);
            chk("stall_grant", grant_id, 1);
            chk("stall_rdy03", {s_ready[3], s_ready[0]}, 0);
        end
        vmask[1] = 1'b1;
        cycle(14);
        chk("stall_beats", out_beats, 6);

        // Asynchronous reset during beat 2 of a req3 packet.
        apply_reset();
        push_pkt(3, 4, 1'b0);
        cycle(2);
        drive();
        #2 resetn = 1'b0;
        #1 check_reset();
        for (int i = 0; i < N; i++) src_q[i].delete();
        model_reset();
        s_valid = '0;
        @(posedge clk);
        #1 resetn = 1'b1;
        push_pkt(1, 1, 1'b0);
        push_pkt(3, 1, 1'b0);
        grant_log.delete();
        cycle(6);
        chk("rst_regrant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);

        // Randomised traffic and backpressure.
        apply_reset();
        rnd_valid = 1'b1; rnd_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (src_q[i].size() == 0) push_pkt(i, $urandom_range(1, 5), 1'b1);
            cycle(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
